out_port: RTL and testbench



---
 rtl/out_port.sv | 117 +++++++++++
 tb/tb_out_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port.sv
// out_port: memory-mapped output latch driving read-back bus, LEDs and a 4-digit hex display.
// Latency: rdata/led one edge after the write strobe; seg/an registered one edge after dig/value.
// Backpressure: none; every write strobe is accepted unconditionally.
//
// Ports:
//   clock, reset (async, active-high)
//   we, wdata[31:0]      one-cycle write strobe and store data
//   rdata[31:0], led[15:0]  latched value (led = low half)
//   seg[6:0] {g..a}, an[3:0]  active-low segments / digit enables, an[0] = value[3:0]
// Optional build macro: OUT_PORT_BLANK_LEADING_EN enables leading-zero blanking of digits 1..3.
module out_port #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      value;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic             cnt_wrap;
    logic [3:0]       nibble;
    logic             blank;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Value register: last write wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= 32'd0;
        end else if (we) begin
            value <= wdata;
        end
    end

    assign rdata = value;
    assign led   = value[15:0];

    // Scan divider. With SCAN_DIV = 1, CNT_MAX is 0 so the counter
    // sits at 0 and the digit advances every cycle.
    assign cnt_wrap = (cnt == CNT_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            dig <= 2'd0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            dig <= dig + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit select and segment pattern are computed from the same dig and
    // value, so an and seg always change on the same edge.
    always_comb begin
        nibble = value[{dig, 2'b00} +: 4];
        blank  = 1'b0;
`ifdef OUT_PORT_BLANK_LEADING_EN
        case (dig)
            2'd1:    blank = (value[15:4]  == 12'd0);
            2'd2:    blank = (value[15:8]  == 8'd0);
            2'd3:    blank = (value[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        if (blank) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'b1111111;
        end else begin
            an_nxt  = ~(4'b0001 << dig);
            seg_nxt = hex7(nibble);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_out_port.sv
// tb_out_port: directed tests of out_port with three scan rates (4, 1, 50000).
// Latency: outputs sampled on the falling edge, inputs driven right after it.
// Backpressure: not applicable.
module tb_out_port;

    logic clock;
    int   checks = 0;
    int   errors = 0;

    // SCAN_DIV = 4 instance
    logic        rst4, we4;
    logic [31:0] wd4, rd4;
    logic [15:0] led4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    // SCAN_DIV = 1 instance
    logic        rst1, we1;
    logic [31:0] wd1, rd1;
    logic [15:0] led1;
    logic [6:0]  seg1;
    logic [3:0]  an1;
    // SCAN_DIV = 50000 instance
    logic        rstk, wek;
    logic [31:0] wdk, rdk;
    logic [15:0] ledk;
    logic [6:0]  segk;
    logic [3:0]  ank;

    out_port #(.SCAN_DIV(4)) u4 (
        .clock(clock), .reset(rst4), .we(we4), .wdata(wd4),
        .rdata(rd4), .led(led4), .seg(seg4), .an(an4)
    );
    out_port #(.SCAN_DIV(1)) u1 (
        .clock(clock), .reset(rst1), .we(we1), .wdata(wd1),
        .rdata(rd1), .led(led1), .seg(seg1), .an(an1)
    );
    out_port #(.SCAN_DIV(50000)) uk (
        .clock(clock), .reset(rstk), .we(wek), .wdata(wdk),
        .rdata(rdk), .led(ledk), .seg(segk), .an(ank)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [6:0] hx(input logic [3:0] n);
        case (n)
            4'h0:    hx = 7'b1000000;
            4'h1:    hx = 7'b1111001;
            4'h2:    hx = 7'b0100100;
            4'h3:    hx = 7'b0110000;
            4'h4:    hx = 7'b0011001;
            4'h5:    hx = 7'b0010010;
            4'h6:    hx = 7'b0000010;
            4'h7:    hx = 7'b1111000;
            4'h8:    hx = 7'b0000000;
            4'h9:    hx = 7'b0010000;
            4'hA:    hx = 7'b0001000;
            4'hB:    hx = 7'b0000011;
            4'hC:    hx = 7'b1000110;
            4'hD:    hx = 7'b0100001;
            4'hE:    hx = 7'b0000110;
            default: hx = 7'b0001110;
        endcase
    endfunction

    // Reset, then release with an optional write sampled by the first edge.
    // Returns at the falling edge after edge 1.
    task automatic restart4(input logic w, input logic [31:0] d);
        rst4 = 1'b1;
        @(negedge clock);
        we4 = w; wd4 = d; rst4 = 1'b0;
        @(negedge clock);
        we4 = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++; if (rd4 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rd4); end
        checks++; if (led4 !== 16'd0) begin errors++; $display("FAIL reset_led got %h want 0", led4); end
        checks++; if (an4 !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an4); end
        checks++; if (seg4 !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg4); end
        rst4 = 1'b0;
        @(negedge clock);
        checks++; if (an4 !== 4'b1110) begin errors++; $display("FAIL first_an got %b want 1110", an4); end
        checks++; if (seg4 !== 7'b1000000) begin errors++; $display("FAIL first_seg got %b want 1000000", seg4); end
        // Mid-run asynchronous reset
        we4 = 1'b1; wd4 = 32'h1234_5678;
        @(negedge clock);
        we4 = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (rd4 !== 32'h1234_5678) begin errors++; $display("FAIL pre_reset_rdata got %h want 12345678", rd4); end
        #2 rst4 = 1'b1;
        #1;
        checks++; if (rd4 !== 32'd0) begin errors++; $display("FAIL async_rdata got %h want 0", rd4); end
        checks++; if (led4 !== 16'd0) begin errors++; $display("FAIL async_led got %h want 0", led4); end
        checks++; if (an4 !== 4'b1111) begin errors++; $display("FAIL async_an got %b want 1111", an4); end
        checks++; if (seg4 !== 7'b1111111) begin errors++; $display("FAIL async_seg got %b want 1111111", seg4); end
        // Write in the same cycle as reset assertion is discarded
        @(negedge clock);
        rst4 = 1'b0;
        repeat (3) @(negedge clock);
        we4 = 1'b1; wd4 = 32'hAAAA_5555;
        #2 rst4 = 1'b1;
        @(negedge clock);
        we4 = 1'b0;
        checks++; if (rd4 !== 32'd0) begin errors++; $display("FAIL reset_write_discard got %h want 0", rd4); end
    endtask

    task automatic test_write_readback;
        logic [31:0] v;
        int d;
        v = 32'hDEAD_12AF;
        restart4(1'b1, v);
        checks++; if (rd4 !== 32'hDEAD_12AF) begin errors++; $display("FAIL wr_rdata got %h want DEAD12AF", rd4); end
        checks++; if (led4 !== 16'h12AF) begin errors++; $display("FAIL wr_led got %h want 12AF", led4); end
        checks++; if (seg4 !== 7'b1000000) begin errors++; $display("FAIL wr_seg_edge1 got %b want 1000000", seg4); end
        for (int k = 2; k <= 17; k++) begin
            @(negedge clock);
            d = ((k - 1) / 4) % 4;
            checks++;
            if (an4 !== ~(4'b0001 << d)) begin
                errors++; $display("FAIL scan_an edge %0d got %b want %b", k, an4, ~(4'b0001 << d));
            end
            checks++;
            if (seg4 !== hx(4'((v >> (4 * d)) & 32'hF))) begin
                errors++; $display("FAIL scan_seg edge %0d got %b want %b", k, seg4, hx(4'((v >> (4 * d)) & 32'hF)));
            end
        end
    endtask

    task automatic test_simultaneous;
        restart4(1'b0, 32'd0);
        repeat (14) @(negedge clock);
        // Edge 16 wraps cnt and moves dig 3 -> 0
        we4 = 1'b1; wd4 = 32'h0000_0005;
        @(negedge clock);
        we4 = 1'b0;
        checks++; if (rd4 !== 32'h5) begin errors++; $display("FAIL wrap_rdata got %h want 5", rd4); end
`ifdef OUT_PORT_BLANK_LEADING_EN
        checks++; if (an4 !== 4'b1111) begin errors++; $display("FAIL wrap_an_old got %b want 1111", an4); end
`else
        checks++; if (an4 !== 4'b0111) begin errors++; $display("FAIL wrap_an_old got %b want 0111", an4); end
`endif
        @(negedge clock);
        checks++; if (an4 !== 4'b1110) begin errors++; $display("FAIL wrap_an_new got %b want 1110", an4); end
        checks++; if (seg4 !== 7'b0010010) begin errors++; $display("FAIL wrap_seg_new got %b want 0010010", seg4); end
        // Back-to-back writes
        we4 = 1'b1; wd4 = 32'h1;
        @(negedge clock);
        checks++; if (rd4 !== 32'h1) begin errors++; $display("FAIL b2b_first got %h want 1", rd4); end
        wd4 = 32'h2;
        @(negedge clock);
        we4 = 1'b0;
        checks++; if (rd4 !== 32'h2) begin errors++; $display("FAIL b2b_second got %h want 2", rd4); end
        @(negedge clock);
        checks++; if (led4 !== 16'h2) begin errors++; $display("FAIL b2b_hold got %h want 2", led4); end
    endtask

    task automatic test_blank;
        logic [3:0] ea [4];
        logic [6:0] es [4];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                restart4(1'b1, 32'h0000_0030);
                ea[0] = 4'b1110; es[0] = 7'b1000000;
                ea[1] = 4'b1101; es[1] = 7'b0110000;
`ifdef OUT_PORT_BLANK_LEADING_EN
                ea[2] = 4'b1111; es[2] = 7'b1111111;
                ea[3] = 4'b1111; es[3] = 7'b1111111;
`else
                ea[2] = 4'b1011; es[2] = 7'b1000000;
                ea[3] = 4'b0111; es[3] = 7'b1000000;
`endif
            end else begin
                restart4(1'b1, 32'h0);
                ea[0] = 4'b1110; es[0] = 7'b1000000;
`ifdef OUT_PORT_BLANK_LEADING_EN
                ea[1] = 4'b1111; es[1] = 7'b1111111;
                ea[2] = 4'b1111; es[2] = 7'b1111111;
                ea[3] = 4'b1111; es[3] = 7'b1111111;
`else
                ea[1] = 4'b1101; es[1] = 7'b1000000;
                ea[2] = 4'b1011; es[2] = 7'b1000000;
                ea[3] = 4'b0111; es[3] = 7'b1000000;
`endif
            end
            repeat (3) @(negedge clock);
            for (int d = 0; d < 4; d++) begin
                if (d > 0) repeat (4) @(negedge clock);
                checks++;
                if (an4 !== ea[d]) begin errors++; $display("FAIL blank_an pass %0d digit %0d got %b want %b", pass, d, an4, ea[d]); end
                checks++;
                if (seg4 !== es[d]) begin errors++; $display("FAIL blank_seg pass %0d digit %0d got %b want %b", pass, d, seg4, es[d]); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [3:0] ea [5];
        logic [6:0] es [5];
        ea[0] = 4'b1110; es[0] = 7'b1000000;
        ea[1] = 4'b1101; es[1] = 7'b0110000;
        ea[2] = 4'b1011; es[2] = 7'b0100100;
        ea[3] = 4'b0111; es[3] = 7'b1111001;
        ea[4] = 4'b1110; es[4] = 7'b0011001;
        @(negedge clock);
        we1 = 1'b1; wd1 = 32'hCAFE_1234; rst1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            we1 = 1'b0;
            checks++;
            if (an1 !== ea[k]) begin errors++; $display("FAIL div1_an edge %0d got %b want %b", k + 1, an1, ea[k]); end
            checks++;
            if (seg1 !== es[k]) begin errors++; $display("FAIL div1_seg edge %0d got %b want %b", k + 1, seg1, es[k]); end
        end
        repeat (100) @(negedge clock);
        checks++; if (rd1 !== 32'hCAFE_1234) begin errors++; $display("FAIL retain_rdata got %h want CAFE1234", rd1); end
        checks++; if (led1 !== 16'h1234) begin errors++; $display("FAIL retain_led got %h want 1234", led1); end
    endtask

    task automatic test_scan_period;
        int n;
        @(negedge clock);
        wek = 1'b1; wdk = 32'h0000_FFFF; rstk = 1'b0;
        @(negedge clock);
        wek = 1'b0;
        n = 0;
        while (ank === 4'b1110 && n < 60000) begin
            n++;
            @(negedge clock);
        end
        checks++; if (n != 50000) begin errors++; $display("FAIL scan_period got %0d cycles want 50000", n); end
        checks++; if (ank !== 4'b1101) begin errors++; $display("FAIL scan_next_an got %b want 1101", ank); end
        checks++; if (segk !== 7'b0001110) begin errors++; $display("FAIL scan_next_seg got %b want 0001110", segk); end
    endtask

    initial begin
        rst4 = 1'b1; we4 = 1'b0; wd4 = 32'd0;
        rst1 = 1'b1; we1 = 1'b0; wd1 = 32'd0;
        rstk = 1'b1; wek = 1'b0; wdk = 32'd0;
        test_reset;
        test_write_readback;
        test_simultaneous;
        test_blank;
        test_wrap;
        test_scan_period;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
